// File: rtl/ara_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ara_pkg
// Description : Shared constants, types and helpers for the vector store unit
//               B-response tracker.
//               - idx_width()          : index width, never less than one bit
//               - NrVInsn              : number of vector instruction IDs
//               - VstuInsnQueueDepth   : store instructions tracked at once
//               - vstu_btrk_entry_t    : one tracked store instruction
//               - RespSlvErr/RespDecErr: AXI error response encodings
// Revision    : 1.0 - initial release
// ============================================================================
package ara_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  localparam int unsigned NrVInsn            = 8;
  localparam int unsigned VstuInsnQueueDepth = 4;

  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed {
    logic [idx_width(NrVInsn)-1:0] id;
    logic [15:0]                   burst_cnt;
    logic                          all_sent;
    logic [15:0]                   b_cnt;
  } vstu_btrk_entry_t;

endpackage
`default_nettype wire

// File: rtl/vstu_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : vstu_credit_counter
// Description : Up/down counter of AW bursts still waiting for a B response.
//               Increments are dropped when full, decrements when empty.
// Ports       : clk_i, rst_ni (async, active low)
//               inc_i   - one burst issued
//               dec_i   - one burst acknowledged
//               count_o - registered count
//               full_o  - count >= MaxOutstanding
//               empty_o - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module vstu_credit_counter
  import ara_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 inc_i,
  input  logic                                 dec_i,
  output logic [idx_width(MaxOutstanding):0]   count_o,
  output logic                                 full_o,
  output logic                                 empty_o
);

  localparam int unsigned CntW = idx_width(MaxOutstanding) + 1;

  logic [CntW-1:0] count_d, count_q;
  logic            inc_eff, dec_eff;

  assign full_o  = (count_q >= CntW'(MaxOutstanding));
  assign empty_o = (count_q == '0);
  assign inc_eff = inc_i && !full_o;
  assign dec_eff = dec_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (inc_eff && !dec_eff) begin
      count_d = count_q + 1'b1;
    end else if (!inc_eff && dec_eff) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/vstu_bresp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : vstu_bresp_tracker
// Description : Tracks store instructions from acceptance through AW burst
//               issue to the last B response, then pulses a per-ID done bit.
//               Circular entry queue with accept / issue / commit pointers.
// Ports       : clk_i, rst_ni (async, active low)
//               acc_*   - accept a store instruction (id)
//               aw_*    - AW burst issue, aw_last_i marks the final burst
//               b_*     - B response
//               vinsn_done_o, store_complete_o - 1-cycle registered pulses
//               store_pending_o, outstanding_o - status
// Options     : VSTU_BRESP_ERR_EN adds err_o / err_id_o, a sticky per-entry
//               error flag set by SLVERR/DECERR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module vstu_bresp_tracker
  import ara_pkg::*;
#(
  parameter int unsigned NrVInsn        = ara_pkg::NrVInsn,
  parameter int unsigned QueueDepth     = VstuInsnQueueDepth,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                acc_valid_i,
  input  logic [idx_width(NrVInsn)-1:0]       acc_id_i,
  output logic                                acc_ready_o,
  input  logic                                aw_valid_i,
  input  logic                                aw_last_i,
  output logic                                aw_ready_o,
  input  logic                                b_valid_i,
  input  logic [1:0]                          b_resp_i,
  output logic                                b_ready_o,
  output logic [NrVInsn-1:0]                  vinsn_done_o,
  output logic                                store_complete_o,
  output logic                                store_pending_o,
  output logic [idx_width(MaxOutstanding):0]  outstanding_o
`ifdef VSTU_BRESP_ERR_EN
  ,
  output logic                                err_o,
  output logic [idx_width(NrVInsn)-1:0]       err_id_o
`endif
);

  localparam int unsigned PtrW  = idx_width(QueueDepth);
  localparam int unsigned CntQW = idx_width(QueueDepth) + 1;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QueueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  vstu_btrk_entry_t entries_d [QueueDepth];
  vstu_btrk_entry_t entries_q [QueueDepth];
  logic [PtrW-1:0]  acc_ptr_d, acc_ptr_q, iss_ptr_d, iss_ptr_q, com_ptr_d, com_ptr_q;
  logic [CntQW-1:0] count_d, count_q;
  // Entries accepted but not yet fully issued; non-zero means an issue entry exists.
  logic [CntQW-1:0] pend_iss_d, pend_iss_q;
  logic [NrVInsn-1:0] done_d, done_q;
  logic             complete_d, complete_q;
  logic             acc_hs, aw_hs, b_hs, retire;
  logic             credit_full, credit_empty;

  vstu_credit_counter #(
    .MaxOutstanding(MaxOutstanding)
  ) u_credit (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (aw_hs),
    .dec_i  (b_hs),
    .count_o(outstanding_o),
    .full_o (credit_full),
    .empty_o(credit_empty)
  );

  // Readies come from registered state only, so aw_ready_o never sees b_valid_i.
  assign acc_ready_o     = (count_q != CntQW'(QueueDepth));
  assign aw_ready_o      = (pend_iss_q != '0) && !credit_full;
  assign b_ready_o       = !credit_empty;
  assign store_pending_o = (count_q != '0);

  assign acc_hs = acc_valid_i && acc_ready_o;
  assign aw_hs  = aw_valid_i && aw_ready_o;
  assign b_hs   = b_valid_i && b_ready_o;
  // Uses the registered all_sent: a final AW landing in the same cycle cannot retire it.
  assign retire = b_hs && entries_q[com_ptr_q].all_sent &&
                  ((entries_q[com_ptr_q].b_cnt + 16'd1) == entries_q[com_ptr_q].burst_cnt);

  always_comb begin
    entries_d  = entries_q;
    acc_ptr_d  = acc_ptr_q;
    iss_ptr_d  = iss_ptr_q;
    com_ptr_d  = com_ptr_q;
    done_d     = '0;
    complete_d = 1'b0;

    if (b_hs) begin
      entries_d[com_ptr_q].b_cnt = entries_q[com_ptr_q].b_cnt + 16'd1;
    end
    if (aw_hs) begin
      entries_d[iss_ptr_q].burst_cnt = entries_q[iss_ptr_q].burst_cnt + 16'd1;
      if (aw_last_i) begin
        entries_d[iss_ptr_q].all_sent = 1'b1;
        iss_ptr_d = ptr_inc(iss_ptr_q);
      end
    end
    if (retire) begin
      com_ptr_d = ptr_inc(com_ptr_q);
      done_d[entries_q[com_ptr_q].id] = 1'b1;
      complete_d = 1'b1;
    end
    // The accept slot is never a live issue/commit entry because the queue is not full.
    if (acc_hs) begin
      entries_d[acc_ptr_q]    = '0;
      entries_d[acc_ptr_q].id = acc_id_i;
      acc_ptr_d = ptr_inc(acc_ptr_q);
    end

    count_d    = count_q + CntQW'(acc_hs) - CntQW'(retire);
    pend_iss_d = pend_iss_q + CntQW'(acc_hs) - CntQW'(aw_hs && aw_last_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q  <= '{default: '0};
      acc_ptr_q  <= '0;
      iss_ptr_q  <= '0;
      com_ptr_q  <= '0;
      count_q    <= '0;
      pend_iss_q <= '0;
      done_q     <= '0;
      complete_q <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      acc_ptr_q  <= acc_ptr_d;
      iss_ptr_q  <= iss_ptr_d;
      com_ptr_q  <= com_ptr_d;
      count_q    <= count_d;
      pend_iss_q <= pend_iss_d;
      done_q     <= done_d;
      complete_q <= complete_d;
    end
  end

  assign vinsn_done_o     = done_q;
  assign store_complete_o = complete_q;

`ifdef VSTU_BRESP_ERR_EN
  logic [QueueDepth-1:0]         err_flag_d, err_flag_q;
  logic                          err_d, err_q;
  logic [idx_width(NrVInsn)-1:0] err_id_d, err_id_q;
  logic                          b_err;

  assign b_err = (b_resp_i == RespSlvErr) || (b_resp_i == RespDecErr);

  always_comb begin
    err_flag_d = err_flag_q;
    if (b_hs && b_err) begin
      err_flag_d[com_ptr_q] = 1'b1;
    end
    if (acc_hs) begin
      err_flag_d[acc_ptr_q] = 1'b0;
    end
    // The retiring B itself may carry the error, so fold it in directly.
    err_d    = retire && (err_flag_q[com_ptr_q] || b_err);
    err_id_d = retire ? entries_q[com_ptr_q].id : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_flag_q <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign err_o    = err_q;
  assign err_id_o = err_id_q;
`else
  logic unused_b_resp;
  assign unused_b_resp = ^b_resp_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vstu_bresp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_vstu_bresp_tracker
// Description : Self-checking bench for vstu_bresp_tracker. A queue-based
//               model of in-flight store instructions predicts every output.
//               Define VSTU_BRESP_ERR_EN to also cover err_o / err_id_o.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vstu_bresp_tracker;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       acc_valid_i, aw_valid_i, aw_last_i, b_valid_i;
  logic [2:0] acc_id_i;
  logic [1:0] b_resp_i;
  logic       acc_ready_o, aw_ready_o, b_ready_o;
  logic [7:0] vinsn_done_o;
  logic       store_complete_o, store_pending_o;
  logic [3:0] outstanding_o;
`ifdef VSTU_BRESP_ERR_EN
  logic       err_o;
  logic [2:0] err_id_o;
`endif

  vstu_bresp_tracker dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .acc_valid_i     (acc_valid_i),
    .acc_id_i        (acc_id_i),
    .acc_ready_o     (acc_ready_o),
    .aw_valid_i      (aw_valid_i),
    .aw_last_i       (aw_last_i),
    .aw_ready_o      (aw_ready_o),
    .b_valid_i       (b_valid_i),
    .b_resp_i        (b_resp_i),
    .b_ready_o       (b_ready_o),
    .vinsn_done_o    (vinsn_done_o),
    .store_complete_o(store_complete_o),
    .store_pending_o (store_pending_o),
    .outstanding_o   (outstanding_o)
`ifdef VSTU_BRESP_ERR_EN
    ,
    .err_o           (err_o),
    .err_id_o        (err_id_o)
`endif
  );

  always #5 clk = ~clk;

  // Model: each instruction knows how many bursts it sent, whether the last
  // one went out, how many responses came back, and whether any was an error.
  typedef struct {
    int id;
    int sent;
    bit all;
    int bcnt;
    bit err;
  } ment_t;

  ment_t      mq[$];
  int         m_out;
  logic [7:0] exp_done;
  bit         exp_cpl;
  bit         exp_err;
  int         exp_err_id;
  int         total = 0;
  int         bad   = 0;

  function automatic bit m_acc_rdy();
    return mq.size() != DEPTH;
  endfunction

  function automatic bit m_aw_rdy();
    bit any = 1'b0;
    foreach (mq[i]) if (!mq[i].all) any = 1'b1;
    return any && (m_out < MAXO);
  endfunction

  function automatic bit m_b_rdy();
    return m_out != 0;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_out      = 0;
    exp_done   = '0;
    exp_cpl    = 1'b0;
    exp_err    = 1'b0;
    exp_err_id = 0;
  endfunction

  // Drive one cycle at the falling edge, advance the model, return at posedge+1.
  task automatic drive_cycle(input bit av, input int aid, input bit wv, input bit wl,
                             input bit bv, input logic [1:0] br);
    bit ahs, whs, bhs, ret, found;
    @(negedge clk);
    acc_valid_i = av;
    acc_id_i    = 3'(aid);
    aw_valid_i  = wv;
    aw_last_i   = wl;
    b_valid_i   = bv;
    b_resp_i    = br;
    ahs = av && m_acc_rdy();
    whs = wv && m_aw_rdy();
    bhs = bv && m_b_rdy();
    ret = 1'b0;
    exp_done   = '0;
    exp_cpl    = 1'b0;
    exp_err    = 1'b0;
    exp_err_id = 0;
    if (bhs) begin
      // Finished when every burst has been answered after the last was sent.
      if (mq[0].all && (mq[0].bcnt + 1 == mq[0].sent)) ret = 1'b1;
      mq[0].bcnt = mq[0].bcnt + 1;
      if (br[1]) mq[0].err = 1'b1;
    end
    if (whs) begin
      found = 1'b0;
      for (int i = 0; i < mq.size(); i++) begin
        if (!found && !mq[i].all) begin
          found = 1'b1;
          mq[i].sent = mq[i].sent + 1;
          if (wl) mq[i].all = 1'b1;
        end
      end
    end
    if (ret) begin
      exp_done[mq[0].id] = 1'b1;
      exp_cpl    = 1'b1;
      exp_err    = mq[0].err;
      exp_err_id = mq[0].id;
      void'(mq.pop_front());
    end
    if (ahs) mq.push_back('{id: aid, sent: 0, all: 1'b0, bcnt: 0, err: 1'b0});
    m_out = m_out + int'(whs) - int'(bhs);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || m_out != 0) && n < 100) begin
      drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b1, 2'b00);
      n++;
    end
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    total++;
    if (store_pending_o !== 1'b0 || outstanding_o !== 4'd0 || n >= 100) begin
      bad++;
      $display("FAIL drain pending=%b outstanding=%0d cycles=%0d required pending=0 outstanding=0",
               store_pending_o, outstanding_o, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    acc_valid_i = 0; acc_id_i = 0; aw_valid_i = 0; aw_last_i = 0; b_valid_i = 0; b_resp_i = 0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({acc_ready_o, aw_ready_o, b_ready_o, store_pending_o, store_complete_o} !== 5'b10000
        || outstanding_o !== 4'd0 || vinsn_done_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs acc/aw/b/pend/cpl=%b%b%b%b%b out=%0d done=%h required 10000 0 00",
               acc_ready_o, aw_ready_o, b_ready_o, store_pending_o, store_complete_o,
               outstanding_o, vinsn_done_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 3, 1'b0, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    total++;
    if (vinsn_done_o !== 8'h00 || store_pending_o !== 1'b1) begin
      bad++;
      $display("FAIL single_first_b done=%h pend=%b required 00 1", vinsn_done_o, store_pending_o);
    end
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    total++;
    if (vinsn_done_o !== 8'h08 || store_complete_o !== 1'b1 || store_pending_o !== 1'b0) begin
      bad++;
      $display("FAIL single_done done=%h cpl=%b pend=%b required 08 1 0",
               vinsn_done_o, store_complete_o, store_pending_o);
    end
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    total++;
    if (vinsn_done_o !== 8'h00 || store_complete_o !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse_width done=%h cpl=%b required 00 0", vinsn_done_o, store_complete_o);
    end
  endtask

  task automatic test_full();
    int ids[4] = '{1, 2, 5, 6};
    foreach (ids[i]) drive_cycle(1'b1, ids[i], 1'b0, 1'b0, 1'b0, 2'b00);
    total++;
    if (acc_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_acc_ready got=%b required 0", acc_ready_o);
    end
    drive_cycle(1'b1, 7, 1'b1, 1'b1, 1'b0, 2'b00);
    drive_cycle(1'b1, 7, 1'b0, 1'b0, 1'b1, 2'b00);
    total++;
    if (acc_ready_o !== 1'b1 || vinsn_done_o !== 8'h02 || mq.size() != 3) begin
      bad++;
      $display("FAIL full_after_retire acc_ready=%b done=%h required 1 02", acc_ready_o, vinsn_done_o);
    end
    drive_cycle(1'b1, 7, 1'b0, 1'b0, 1'b0, 2'b00);
    total++;
    if (acc_ready_o !== 1'b0 || store_pending_o !== 1'b1) begin
      bad++;
      $display("FAIL full_refill acc_ready=%b pend=%b required 0 1", acc_ready_o, store_pending_o);
    end
    drain();
  endtask

  task automatic test_credit();
    drive_cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (8) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    total++;
    if (aw_ready_o !== 1'b0 || outstanding_o !== 4'd8) begin
      bad++;
      $display("FAIL credit_full aw_ready=%b out=%0d required 0 8", aw_ready_o, outstanding_o);
    end
    drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b1, 2'b00);
    total++;
    if (aw_ready_o !== 1'b1 || outstanding_o !== 4'd7) begin
      bad++;
      $display("FAIL credit_release aw_ready=%b out=%0d required 1 7", aw_ready_o, outstanding_o);
    end
    drain();
  endtask

  task automatic test_overlap();
    drive_cycle(1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b1, 2'b00);
    total++;
    if (outstanding_o !== 4'd1 || vinsn_done_o !== 8'h00) begin
      bad++;
      $display("FAIL overlap_same_cycle out=%0d done=%h required 1 00", outstanding_o, vinsn_done_o);
    end
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    total++;
    if (vinsn_done_o !== 8'h01 || store_pending_o !== 1'b0 || outstanding_o !== 4'd0) begin
      bad++;
      $display("FAIL overlap_retire done=%h pend=%b out=%0d required 01 0 0",
               vinsn_done_o, store_pending_o, outstanding_o);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 2, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    total++;
    if (outstanding_o !== 4'd3) begin
      bad++;
      $display("FAIL areset_pre out=%0d required 3", outstanding_o);
    end
    @(negedge clk);
    acc_valid_i = 0; aw_valid_i = 0; aw_last_i = 0; b_valid_i = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({acc_ready_o, aw_ready_o, b_ready_o, store_pending_o} !== 4'b1000 || outstanding_o !== 4'd0) begin
      bad++;
      $display("FAIL areset_async acc/aw/b/pend=%b%b%b%b out=%0d required 1000 0",
               acc_ready_o, aw_ready_o, b_ready_o, store_pending_o, outstanding_o);
    end
    m_reset();
    @(posedge clk);
    #1;
    total++;
    if (vinsn_done_o !== 8'h00 || store_complete_o !== 1'b0) begin
      bad++;
      $display("FAIL areset_no_done done=%h cpl=%b required 00 0", vinsn_done_o, store_complete_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 4, 1'b0, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    total++;
    if (vinsn_done_o !== 8'h10 || store_pending_o !== 1'b0) begin
      bad++;
      $display("FAIL areset_next done=%h pend=%b required 10 0", vinsn_done_o, store_pending_o);
    end
  endtask

`ifdef VSTU_BRESP_ERR_EN
  task automatic test_err();
    drive_cycle(1'b1, 7, 1'b0, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    drive_cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    total++;
    if (err_o !== 1'b1 || err_id_o !== 3'd7 || vinsn_done_o !== 8'h80) begin
      bad++;
      $display("FAIL err_slverr err=%b id=%0d done=%h required 1 7 80", err_o, err_id_o, vinsn_done_o);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      total++;
      if (acc_ready_o !== m_acc_rdy() || aw_ready_o !== m_aw_rdy() || b_ready_o !== m_b_rdy()) begin
        bad++;
        $display("FAIL rnd_ready cyc=%0d acc/aw/b=%b%b%b required %b%b%b", c,
                 acc_ready_o, aw_ready_o, b_ready_o, m_acc_rdy(), m_aw_rdy(), m_b_rdy());
      end
      total++;
      if (store_pending_o !== (mq.size() != 0) || outstanding_o !== 4'(m_out)) begin
        bad++;
        $display("FAIL rnd_status cyc=%0d pend=%b out=%0d required %b %0d", c,
                 store_pending_o, outstanding_o, (mq.size() != 0), m_out);
      end
      total++;
      if (vinsn_done_o !== exp_done || store_complete_o !== exp_cpl) begin
        bad++;
        $display("FAIL rnd_done cyc=%0d done=%h cpl=%b required %h %b", c,
                 vinsn_done_o, store_complete_o, exp_done, exp_cpl);
      end
`ifdef VSTU_BRESP_ERR_EN
      total++;
      if (err_o !== exp_err || err_id_o !== 3'(exp_err_id)) begin
        bad++;
        $display("FAIL rnd_err cyc=%0d err=%b id=%0d required %b %0d", c,
                 err_o, err_id_o, exp_err, exp_err_id);
      end
`endif
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_credit();
    test_overlap();
    test_async_reset();
`ifdef VSTU_BRESP_ERR_EN
    test_err();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
